// File: rtl/bcd_to_bin_seq_pkg.sv
// bcd_to_bin_seq_pkg: shared FSM states and BCD digit helpers for the BCD converters.
package bcd_to_bin_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic is_bad_digit(input logic [3:0] d);
        return d > BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_to_bin_seq_mul10_add.sv
// mul10_add: combinational y = a*10 + d using shift-add, truncated to BW bits.
module mul10_add #(
    parameter int BW = 7
) (
    input  logic [BW-1:0] a,
    input  logic [3:0]    d,
    output logic [BW-1:0] y
);

    assign y = (a << 3) + (a << 1) + BW'(d);

endmodule

// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: MSD-first sequential BCD-to-binary converter with valid/ready on both sides.
module bcd_to_bin_seq
    import bcd_to_bin_seq_pkg::*;
#(
    parameter int NDIG = 2,
    parameter int BW   = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4*NDIG-1:0] bcd_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [BW-1:0]     bin_out,
    output logic              err,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int CW = $clog2(NDIG + 1);
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    state_t            state_q, state_d;
    logic [BW-1:0]     acc_q, acc_d, acc_nx;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [4*NDIG-1:0] dig_q, dig_d;
    logic              err_r_q, err_r_d;
    logic [BW-1:0]     bin_out_q, bin_out_d;
    logic              err_q, err_d;
    logic              out_valid_q, out_valid_d;
    logic              bad;

    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < NDIG; i++) bad = bad | is_bad_digit(bcd_in[4*i +: 4]);
    end

    mul10_add #(.BW(BW)) u_mul10_add (
        .a(acc_q),
        .d(dig_q[4*NDIG-1 -: 4]),
        .y(acc_nx)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        dig_d       = dig_q;
        err_r_d     = err_r_q;
        bin_out_d   = bin_out_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_IDLE: if (in_valid) begin
                dig_d   = bcd_in;
                acc_d   = '0;
                cnt_d   = '0;
                err_r_d = bad;
                state_d = S_CONV;
            end
            S_CONV: begin
                acc_d = acc_nx;
                dig_d = dig_q << 4;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    bin_out_d   = err_r_q ? '0 : acc_nx;
                    err_d       = err_r_q;
                end
            end
            S_DONE: if (out_ready) begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
                bin_out_d   = '0;
                err_d       = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            dig_q       <= '0;
            err_r_q     <= 1'b0;
            bin_out_q   <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            dig_q       <= dig_d;
            err_r_q     <= err_r_d;
            bin_out_q   <= bin_out_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign bin_out   = bin_out_q;
    assign err       = err_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb_bcd_to_bin_seq: vector table, random model checks and corner sequences for two converter sizes.
module tb_bcd_to_bin_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  bcd_in_a = '0;
    logic        in_valid_a = 1'b0, out_ready_a = 1'b0;
    logic        in_ready_a, err_a, out_valid_a;
    logic [6:0]  bin_out_a;
    logic [11:0] bcd_in_b = '0;
    logic        in_valid_b = 1'b0, out_ready_b = 1'b0;
    logic        in_ready_b, err_b, out_valid_b;
    logic [9:0]  bin_out_b;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] bcd;
        logic [6:0] val;
        logic       err;
        int         bp;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    bcd_to_bin_seq #(.NDIG(2), .BW(7)) dut_a (
        .clk(clk), .reset(reset), .bcd_in(bcd_in_a), .in_valid(in_valid_a),
        .in_ready(in_ready_a), .bin_out(bin_out_a), .err(err_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a)
    );

    bcd_to_bin_seq #(.NDIG(3), .BW(10)) dut_b (
        .clk(clk), .reset(reset), .bcd_in(bcd_in_b), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .bin_out(bin_out_b), .err(err_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Decimal value of the low n BCD digits; any digit above 9 forces 0 and flags an error.
    function automatic int ref_val(input logic [11:0] b, input int n, output logic e);
        int v;
        int d;
        v = 0;
        e = 1'b0;
        for (int i = n - 1; i >= 0; i--) begin
            d = int'((b >> (4 * i)) & 12'hF);
            if (d > 9) e = 1'b1;
            v = v * 10 + d;
        end
        return e ? 0 : v;
    endfunction

    task automatic run_a(input logic [7:0] bcd, input logic [6:0] ev, input logic ee, input int bp);
        int lat;
        bcd_in_a   = bcd;
        in_valid_a = 1'b1;
        lat = 0;
        while (!in_ready_a && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("a_in_ready_before_accept", int'(in_ready_a), 1);
        @(posedge clk); #1;
        in_valid_a = 1'b0;
        bcd_in_a   = 8'($urandom);
        chk("a_in_ready_in_conv", int'(in_ready_a), 0);
        lat = 0;
        while (!out_valid_a && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("a_latency", lat, 2);
        chk("a_bin_out", int'(bin_out_a), int'(ev));
        chk("a_err", int'(err_a), int'(ee));
        for (int k = 0; k < bp; k++) begin
            in_valid_a = 1'b1;
            bcd_in_a   = 8'($urandom);
            @(posedge clk); #1;
            chk("a_hold_valid", int'(out_valid_a), 1);
            chk("a_hold_bin_out", int'(bin_out_a), int'(ev));
            chk("a_hold_err", int'(err_a), int'(ee));
            chk("a_hold_in_ready", int'(in_ready_a), 0);
        end
        in_valid_a  = 1'b0;
        out_ready_a = 1'b1;
        @(posedge clk); #1;
        out_ready_a = 1'b0;
        chk("a_valid_after_hs", int'(out_valid_a), 0);
        chk("a_in_ready_after_hs", int'(in_ready_a), 1);
        chk("a_bin_out_idle", int'(bin_out_a), 0);
        chk("a_err_idle", int'(err_a), 0);
    endtask

    task automatic run_b(input logic [11:0] bcd, input logic [9:0] ev, input logic ee);
        int lat;
        bcd_in_b   = bcd;
        in_valid_b = 1'b1;
        lat = 0;
        while (!in_ready_b && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("b_in_ready_before_accept", int'(in_ready_b), 1);
        @(posedge clk); #1;
        in_valid_b = 1'b0;
        bcd_in_b   = 12'($urandom);
        lat = 0;
        while (!out_valid_b && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("b_latency", lat, 3);
        chk("b_bin_out", int'(bin_out_b), int'(ev));
        chk("b_err", int'(err_b), int'(ee));
        out_ready_b = 1'b1;
        @(posedge clk); #1;
        out_ready_b = 1'b0;
        chk("b_valid_after_hs", int'(out_valid_b), 0);
        chk("b_in_ready_after_hs", int'(in_ready_b), 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [11:0] r;
        logic        e;
        int          v;
        vecs[0] = '{8'h59, 7'd59, 1'b0, 0};
        vecs[1] = '{8'h00, 7'd0,  1'b0, 0};
        vecs[2] = '{8'h99, 7'd99, 1'b0, 0};
        vecs[3] = '{8'h3A, 7'd0,  1'b1, 0};
        vecs[4] = '{8'h27, 7'd27, 1'b0, 5};
        vecs[5] = '{8'hA0, 7'd0,  1'b1, 5};
        vecs[6] = '{8'h10, 7'd10, 1'b0, 0};
        vecs[7] = '{8'h09, 7'd9,  1'b0, 1};
        vecs[8] = '{8'hFF, 7'd0,  1'b1, 0};
        vecs[9] = '{8'h90, 7'd90, 1'b0, 0};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_a_in_ready", int'(in_ready_a), 1);
        chk("rst_a_out_valid", int'(out_valid_a), 0);
        chk("rst_a_bin_out", int'(bin_out_a), 0);
        chk("rst_a_err", int'(err_a), 0);
        chk("rst_b_in_ready", int'(in_ready_b), 1);
        chk("rst_b_out_valid", int'(out_valid_b), 0);

        for (int i = 0; i < 10; i++) run_a(vecs[i].bcd, vecs[i].val, vecs[i].err, vecs[i].bp);

        // Reset lands on the edge that would have completed the conversion.
        bcd_in_a   = 8'h77;
        in_valid_a = 1'b1;
        @(posedge clk); #1;
        in_valid_a = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst_out_valid", int'(out_valid_a), 0);
        chk("midrst_bin_out", int'(bin_out_a), 0);
        chk("midrst_err", int'(err_a), 0);
        chk("midrst_in_ready", int'(in_ready_a), 1);
        repeat (3) begin
            @(posedge clk); #1;
            chk("midrst_no_result", int'(out_valid_a), 0);
        end
        run_a(8'h42, 7'd42, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            r = 12'($urandom);
            if (i % 2 == 0) r = {4'h0, 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            v = ref_val(r, 2, e);
            run_a(r[7:0], 7'(v), e, int'($urandom_range(0, 2)));
        end

        run_b(12'h255, 10'd255, 1'b0);
        run_b(12'h999, 10'd999, 1'b0);
        run_b(12'h000, 10'd0, 1'b0);
        run_b(12'h9B1, 10'd0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            r = 12'($urandom);
            if (i % 2 == 0) r = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            v = ref_val(r, 3, e);
            run_b(r, 10'(v), e);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
